// File: rtl/codec_adc_capture_pkg.sv
// Shared constants, state encoding and helpers for the codec ADC capture path.
// Samples are stored low byte first, matching WAV PCM.
package capture_pkg;

    localparam int CAPTURE_SAMPLE_BITS = 16;
    localparam int BIT_CNT_BITS        = $clog2(CAPTURE_SAMPLE_BITS);
    localparam bit BYTE_ORDER_LE       = 1'b1;

    typedef logic [2:0] capture_state_t;

    localparam capture_state_t ST_IDLE       = 3'd0;
    localparam capture_state_t ST_WAIT_FRAME = 3'd1;
    localparam capture_state_t ST_SHIFT      = 3'd2;
    localparam capture_state_t ST_WRITE_LO   = 3'd3;
    localparam capture_state_t ST_WRITE_HI   = 3'd4;
    localparam capture_state_t ST_HOLD       = 3'd5;

    // Magnitude of a two's-complement sample; -32768 saturates to 32767.
    function automatic logic [15:0] sat_abs(input logic [15:0] s);
        if (s == 16'h8000) return 16'h7FFF;
        else if (s[15])    return ~s + 16'd1;
        else               return s;
    endfunction

endpackage

// File: rtl/codec_adc_capture_rx_shifter.sv
// i2s_rx_shifter: synchronizes the codec BCLK/LRCK/DATA pins, detects edges and
// assembles one 16-bit word per LRCK phase, MSB on the first BCLK rise after the edge.
module i2s_rx_shifter
    import capture_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           aud_bclk_i,
    input  logic                           aud_adclrck_i,
    input  logic                           aud_adcdat_i,
    output logic                           lrck_fall_o,
    output logic                           sample_valid_o,
    output logic [CAPTURE_SAMPLE_BITS-1:0] sample_o,
    output logic                           sample_is_right_o
);
    localparam logic [BIT_CNT_BITS-1:0] LAST_BIT = BIT_CNT_BITS'(CAPTURE_SAMPLE_BITS - 1);

    logic [1:0]                     r_bclk_sync;
    logic [1:0]                     r_lrck_sync;
    logic [1:0]                     r_dat_sync;
    logic                           r_bclk_prev;
    logic                           r_lrck_prev;
    logic                           r_bclk_rise;
    logic                           r_lrck_edge;
    logic                           r_lrck_level;
    logic                           r_dat_bit;
    logic [CAPTURE_SAMPLE_BITS-2:0] r_shift;
    logic [BIT_CNT_BITS-1:0]        r_bit_cnt;
    logic                           r_active;
    logic                           r_is_right;
    logic                           w_last_bit;

    // Edge pulses are registered so BCLK reaches the shift logic 3 clk after the pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bclk_sync  <= '0;
            r_lrck_sync  <= '0;
            r_dat_sync   <= '0;
            r_bclk_prev  <= 1'b0;
            r_lrck_prev  <= 1'b0;
            r_bclk_rise  <= 1'b0;
            r_lrck_edge  <= 1'b0;
            r_lrck_level <= 1'b0;
            r_dat_bit    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            r_bclk_sync  <= {r_bclk_sync[0], aud_bclk_i};
            r_lrck_sync  <= {r_lrck_sync[0], aud_adclrck_i};
            r_dat_sync   <= {r_dat_sync[0], aud_adcdat_i};
            r_bclk_prev  <= r_bclk_sync[1];
            r_lrck_prev  <= r_lrck_sync[1];
            r_bclk_rise  <= r_bclk_sync[1] & ~r_bclk_prev;
            r_lrck_edge  <= r_lrck_sync[1] ^ r_lrck_prev;
            r_lrck_level <= r_lrck_sync[1];
            r_dat_bit    <= r_dat_sync[1];
        end
    end

    assign w_last_bit = r_bclk_rise & r_active & ~r_lrck_edge & (r_bit_cnt == LAST_BIT);

    // Any LRCK edge realigns the word, so a stray partial word never leaks into the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_active   <= 1'b0;
            r_is_right <= 1'b0;
        end else if (r_lrck_edge) begin
            r_bit_cnt  <= '0;
            r_active   <= 1'b1;
            r_is_right <= r_lrck_level;
        end else if (r_bclk_rise && r_active) begin
            r_shift   <= {r_shift[CAPTURE_SAMPLE_BITS-3:0], r_dat_bit};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_last_bit) r_active <= 1'b0;
        end
    end

    assign lrck_fall_o       = r_lrck_edge & ~r_lrck_level;
    assign sample_valid_o    = w_last_bit;
    assign sample_o          = {r_shift, r_dat_bit};
    assign sample_is_right_o = r_is_right;

endmodule

// File: rtl/codec_adc_capture.sv
// codec_adc_capture: writes captured ADC samples as little-endian PCM into a RAM double
// buffer with full/ack handshake. Define CAPTURE_PEAK_METER_EN to build the peak meter.
module codec_adc_capture
    import capture_pkg::*;
#(
    parameter int BUFFER_ADDR_BITS = 9,
    parameter int SAMPLE_BITS      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        capture_enable_i,
    input  logic                        capture_stereo_i,
    input  logic                        aud_bclk_i,
    input  logic                        aud_adclrck_i,
    input  logic                        aud_adcdat_i,
    output logic [BUFFER_ADDR_BITS-1:0] buffer_addr_o,
    output logic                        buffer_sel_o,
    output logic                        buffer_wren_o,
    output logic [7:0]                  buffer_data_o,
    output logic                        buffer_full_o,
    input  logic                        buffer_full_ack_i,
    output logic                        overrun_o,
    output logic [15:0]                 peak_o
);
    localparam logic [BUFFER_ADDR_BITS-1:0] ADDR_LAST = '1;
    localparam logic [BUFFER_ADDR_BITS-1:0] ADDR_ONE  = BUFFER_ADDR_BITS'(1);

    capture_state_t                r_state;
    logic [BUFFER_ADDR_BITS-1:0]   r_addr;
    logic                          r_sel;
    logic                          r_full;
    logic                          r_overrun;
    logic                          r_stereo;
    logic [SAMPLE_BITS-1:0]        r_sample;

    logic                          w_lrck_fall;
    logic                          w_sample_valid;
    logic [CAPTURE_SAMPLE_BITS-1:0] w_sample;
    logic                          w_sample_is_right;
    logic                          w_store;
    logic                          w_wrap;
    logic                          w_half_done;
    logic [7:0]                    w_byte;

    i2s_rx_shifter u_rx (
        .clk               (clk),
        .rst_n             (rst_n),
        .aud_bclk_i        (aud_bclk_i),
        .aud_adclrck_i     (aud_adclrck_i),
        .aud_adcdat_i      (aud_adcdat_i),
        .lrck_fall_o       (w_lrck_fall),
        .sample_valid_o    (w_sample_valid),
        .sample_o          (w_sample),
        .sample_is_right_o (w_sample_is_right)
    );

    assign w_store     = capture_enable_i && (r_state == ST_SHIFT) && w_sample_valid
                         && (r_stereo || !w_sample_is_right);
    assign w_wrap      = (r_state == ST_WRITE_HI) && (r_addr == ADDR_LAST);
    assign w_half_done = capture_enable_i && w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_sel     <= 1'b0;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
            r_stereo  <= 1'b0;
            r_sample  <= '0;
        end else begin
            // The ack is applied first; a wrap in the same cycle may set full again below.
            if (buffer_full_ack_i) r_full <= 1'b0;

            if (!capture_enable_i) begin
                r_state   <= ST_IDLE;
                r_addr    <= '0;
                r_overrun <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state  <= ST_WAIT_FRAME;
                        r_stereo <= capture_stereo_i;
                        r_addr   <= '0;
                    end
                    ST_WAIT_FRAME: begin
                        if (w_lrck_fall) r_state <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (w_store) begin
                            r_sample <= w_sample;
                            r_state  <= ST_WRITE_LO;
                        end
                    end
                    ST_WRITE_LO: begin
                        r_addr  <= r_addr + ADDR_ONE;
                        r_state <= ST_WRITE_HI;
                    end
                    ST_WRITE_HI: begin
                        if (!w_wrap) begin
                            r_addr  <= r_addr + ADDR_ONE;
                            r_state <= ST_SHIFT;
                        end else if (!r_full || buffer_full_ack_i) begin
                            r_full  <= 1'b1;
                            r_sel   <= ~r_sel;
                            r_addr  <= '0;
                            r_state <= ST_SHIFT;
                        end else begin
                            r_overrun <= 1'b1;
                            r_state   <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        // Resume on a left frame so stereo pairs stay aligned in the new half.
                        if (buffer_full_ack_i) begin
                            r_sel   <= ~r_sel;
                            r_addr  <= '0;
                            r_state <= ST_WAIT_FRAME;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        // NOTE: default assignment first keeps this combinational block latch-free.
        w_byte = '0;
        if (r_state == ST_WRITE_LO)
            w_byte = BYTE_ORDER_LE ? r_sample[7:0] : r_sample[15:8];
        else if (r_state == ST_WRITE_HI)
            w_byte = BYTE_ORDER_LE ? r_sample[15:8] : r_sample[7:0];
    end

    assign buffer_addr_o = r_addr;
    assign buffer_sel_o  = r_sel;
    assign buffer_wren_o = (r_state == ST_WRITE_LO) || (r_state == ST_WRITE_HI);
    assign buffer_data_o = w_byte;
    assign buffer_full_o = r_full;
    assign overrun_o     = r_overrun;

`ifdef CAPTURE_PEAK_METER_EN
    logic [15:0] r_peak;
    logic [15:0] w_sample_abs;

    assign w_sample_abs = sat_abs(w_sample);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 r_peak <= '0;
        else if (w_half_done)                       r_peak <= '0;
        else if (w_store && w_sample_abs > r_peak)  r_peak <= w_sample_abs;
    end

    assign peak_o = r_peak;
`else
    assign peak_o = '0;
`endif

endmodule

// File: tb/tb_codec_adc_capture.sv
// Self-checking bench for codec_adc_capture: drives I2S frames, predicts RAM writes
// into a scoreboard queue and compares them as the DUT strobes wren.
module tb_codec_adc_capture;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          capture_enable;
    logic          capture_stereo;
    logic          aud_bclk;
    logic          aud_adclrck;
    logic          aud_adcdat;
    logic [AW-1:0] buffer_addr;
    logic          buffer_sel;
    logic          buffer_wren;
    logic [7:0]    buffer_data;
    logic          buffer_full;
    logic          buffer_full_ack;
    logic          overrun;
    logic [15:0]   peak;

    always #5 clk = ~clk;

    codec_adc_capture #(.BUFFER_ADDR_BITS(AW), .SAMPLE_BITS(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .capture_enable_i  (capture_enable),
        .capture_stereo_i  (capture_stereo),
        .aud_bclk_i        (aud_bclk),
        .aud_adclrck_i     (aud_adclrck),
        .aud_adcdat_i      (aud_adcdat),
        .buffer_addr_o     (buffer_addr),
        .buffer_sel_o      (buffer_sel),
        .buffer_wren_o     (buffer_wren),
        .buffer_data_o     (buffer_data),
        .buffer_full_o     (buffer_full),
        .buffer_full_ack_i (buffer_full_ack),
        .overrun_o         (overrun),
        .peak_o            (peak)
    );

    typedef struct packed {
        logic          sel;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          hold;
    } wr_t;

    wr_t           exp_q[$];
    int            checks   = 0;
    int            errors   = 0;
    int            n_writes = 0;
    logic          m_sel    = 1'b0;
    logic          m_full   = 1'b0;
    logic          m_hold   = 1'b0;
    logic          m_stereo = 1'b0;
    logic [AW-1:0] m_addr   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: where each stored sample's two bytes should land.
    task automatic exp_sample(input logic [15:0] s);
        wr_t e;
        if (m_hold) return;
        e.sel  = m_sel;
        e.addr = m_addr;
        e.data = s[7:0];
        e.hold = 1'b0;
        exp_q.push_back(e);
        m_addr = m_addr + 1'b1;
        e.addr = m_addr;
        e.data = s[15:8];
        if (m_addr == '1) begin
            e.hold = m_full;
            if (m_full) m_hold = 1'b1;
            else begin
                m_full = 1'b1;
                m_sel  = ~m_sel;
                m_addr = '0;
            end
        end else begin
            m_addr = m_addr + 1'b1;
        end
        exp_q.push_back(e);
    endtask

    // BCLK period is 4 clk; LRCK and data change while BCLK is low.
    task automatic send_word(input logic lr, input logic [15:0] w, input int nbits);
        for (int i = 15; i > 15 - nbits; i--) begin
            aud_adclrck = lr;
            aud_adcdat  = w[i];
            #20 aud_bclk = 1'b1;
            #20 aud_bclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        exp_sample(l);
        if (m_stereo) exp_sample(r);
        send_word(1'b0, l, 16);
        send_word(1'b1, r, 16);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        buffer_full_ack = 1'b1;
        @(negedge clk);
        buffer_full_ack = 1'b0;
        m_full = 1'b0;
        if (m_hold) begin
            m_sel  = ~m_sel;
            m_addr = '0;
            m_hold = 1'b0;
        end
    endtask

    logic pend_wrap = 1'b0;
    logic pend_hold = 1'b0;
    logic pend_sel  = 1'b0;

    // Scoreboard: every write strobe pops one prediction; wrap effects checked 1 clk later.
    always @(negedge clk) begin
        wr_t e;
        if (pend_wrap) begin
            pend_wrap = 1'b0;
            if (pend_hold) begin
                chk("hold_overrun", {31'd0, overrun}, 32'd1);
                chk("hold_sel", {31'd0, buffer_sel}, {31'd0, pend_sel});
            end else begin
                chk("wrap_full", {31'd0, buffer_full}, 32'd1);
                chk("wrap_sel", {31'd0, buffer_sel}, {31'd0, !pend_sel});
                chk("wrap_addr", {23'd0, buffer_addr}, 32'd0);
            end
        end
        if (buffer_wren === 1'b1) begin
            n_writes++;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed sel=%0d addr=%0d data=0x%0h expected no write",
                       buffer_sel, buffer_addr, buffer_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("write", {14'd0, buffer_sel, buffer_addr, buffer_data},
                    {14'd0, e.sel, e.addr, e.data});
                if (e.addr == '1) begin
                    pend_wrap = 1'b1;
                    pend_hold = e.hold;
                    pend_sel  = e.sel;
                end
            end
        end
    end

    initial begin
        int n0;
        capture_enable  = 1'b0;
        capture_stereo  = 1'b0;
        aud_bclk        = 1'b0;
        aud_adclrck     = 1'b1;
        aud_adcdat      = 1'b0;
        buffer_full_ack = 1'b0;
        rst_n           = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_wren", {31'd0, buffer_wren}, 32'd0);
        chk("rst_addr", {23'd0, buffer_addr}, 32'd0);
        chk("rst_sel", {31'd0, buffer_sel}, 32'd0);
        chk("rst_data", {24'd0, buffer_data}, 32'd0);
        chk("rst_full", {31'd0, buffer_full}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_peak", {16'd0, peak}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Stereo: one frame, four bytes little-endian.
        capture_stereo = 1'b1;
        m_stereo       = 1'b1;
        capture_enable = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(16'h1234, 16'hABCD);
        repeat (10) @(negedge clk);
        chk("stereo_drain", exp_q.size(), 32'd0);
        chk("stereo_addr", {23'd0, buffer_addr}, 32'd4);

        // Enable dropped mid-word: the partial word is discarded.
        send_word(1'b0, 16'h5A5A, 8);
        capture_enable = 1'b0;
        m_addr = '0;
        m_hold = 1'b0;
        n0 = n_writes;
        repeat (3) @(negedge clk);
        chk("disable_addr", {23'd0, buffer_addr}, 32'd0);
        capture_enable = 1'b1;
        send_word(1'b0, 16'h5A00, 8);
        send_word(1'b1, 16'h1357, 16);
        repeat (10) @(negedge clk);
        chk("partial_no_write", n_writes, n0);
        send_frame(16'hC0DE, 16'h0BEE);
        repeat (10) @(negedge clk);
        chk("restart_drain", exp_q.size(), 32'd0);
        chk("restart_addr", {23'd0, buffer_addr}, 32'd4);

        // Mono: only the left word is stored.
        capture_enable = 1'b0;
        repeat (2) @(negedge clk);
        capture_stereo = 1'b0;
        m_stereo       = 1'b0;
        m_addr         = '0;
        capture_enable = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(16'h00FF, 16'h7777);
        send_frame(16'h00FF, 16'h7777);
        repeat (10) @(negedge clk);
        chk("mono_drain", exp_q.size(), 32'd0);
        chk("mono_addr", {23'd0, buffer_addr}, 32'd4);

        // 128 stereo frames fill half 0.
        capture_enable = 1'b0;
        repeat (2) @(negedge clk);
        capture_stereo = 1'b1;
        m_stereo       = 1'b1;
        m_addr         = '0;
        capture_enable = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 128; i++)
            send_frame(16'(i * 16'h0101), 16'(16'h8000 ^ i));
        repeat (10) @(negedge clk);
        chk("fill_drain", exp_q.size(), 32'd0);
        chk("fill_full", {31'd0, buffer_full}, 32'd1);
        chk("fill_sel", {31'd0, buffer_sel}, 32'd1);
        chk("peak_cleared", {16'd0, peak}, 32'd0);
        pulse_ack();
        chk("ack_full", {31'd0, buffer_full}, 32'd0);

        send_frame(16'h0100, 16'hF000);
        repeat (10) @(negedge clk);
`ifdef CAPTURE_PEAK_METER_EN
        chk("peak_value", {16'd0, peak}, 32'h1000);
`else
        chk("peak_tied", {16'd0, peak}, 32'd0);
`endif

        // Fill half 1, then half 0 without ack -> overrun.
        for (int i = 0; i < 127; i++)
            send_frame(16'(i), 16'(~i));
        for (int i = 0; i < 128; i++)
            send_frame(16'(i + 7), 16'(i * 3));
        repeat (10) @(negedge clk);
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        n0 = n_writes;
        for (int i = 0; i < 3; i++)
            send_frame(16'h1111, 16'h2222);
        repeat (10) @(negedge clk);
        chk("hold_no_write", n_writes, n0);

        pulse_ack();
        repeat (2) @(negedge clk);
        chk("resume_sel", {31'd0, buffer_sel}, {31'd0, m_sel});
        chk("resume_addr", {23'd0, buffer_addr}, 32'd0);
        send_frame(16'h2468, 16'h1357);
        repeat (10) @(negedge clk);
        chk("resume_drain", exp_q.size(), 32'd0);

        capture_enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("disable_overrun", {31'd0, overrun}, 32'd0);
        chk("disable_sel_kept", {31'd0, buffer_sel}, {31'd0, m_sel});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/codec_adc_capture.md
# codec_adc_capture

Record-path counterpart of the playback chain: deserializes the audio codec's ADC I2S stream (left-justified I2S, 16-bit, MSB one BCLK after LRCK edge) and writes little-endian PCM bytes into one half of the dual-port RAM double buffer. When a half fills, the block signals the downstream consumer and switches halves. The downstream consumer is a future SD block writer, which drains the full half to the card. The block sits beside `Codec` (which owns the clock generation) and writes the RAM port that the playback path leaves unused when recording.

## Interface
Parameters:
- `BUFFER_ADDR_BITS`, 9, byte address width of one buffer half (512 B = one SD block)
- `SAMPLE_BITS`, 16, bits per channel sample; must be 16 in this revision

Ports:
- `clk`  in  1  system clock (200 MHz); one clock; reset is asynchronous and active-low
- `rst_n`  in  1  asynchronous active-low reset
- `capture_enable_i`  in  1  level; start/stop capture
- `capture_stereo_i`  in  1  1 = store L and R, 0 = store L only; sampled when capture starts
- `aud_bclk_i`  in  1  codec bit clock (asynchronous)
- `aud_adclrck_i`  in  1  codec ADC LR clock; 0 = left
- `aud_adcdat_i`  in  1  codec ADC serial data
- `buffer_addr_o`  out  BUFFER_ADDR_BITS  write byte address within the half
- `buffer_sel_o`  out  1  half currently being written (RAM address MSB)
- `buffer_wren_o`  out  1  write strobe, one cycle per byte
- `buffer_data_o`  out  8  write byte
- `buffer_full_o`  out  1  level; completed half (`!buffer_sel_o`) awaits draining
- `buffer_full_ack_i`  in  1  consumer done with completed half
- `overrun_o`  out  1  sticky; a half completed before the previous one was acked
- `peak_o`  out  16  peak meter (see Configuration)

## Operation
- Reset values: all outputs 0; state IDLE.
- `aud_*` inputs pass through 2-flop synchronizers; the block acts on a BCLK rising edge detected from the synchronized signal, one pulse per edge.
- States: IDLE, WAIT_FRAME, SHIFT, WRITE_LO, WRITE_HI, HOLD.
- IDLE: `capture_enable_i`=1 -> WAIT_FRAME; latch `capture_stereo_i`; address := 0.
- WAIT_FRAME: a synchronized LRCK falling edge (start of a left frame) arms capture. The first BCLK rise after the edge samples the MSB. Then -> SHIFT.
- SHIFT: shift one bit per BCLK rise, MSB first. After 16 bits, latch the sample -> WRITE_LO. In mono, a right-channel word is shifted but not stored; the block returns to WAIT_FRAME-style alignment on the next LRCK edge. In stereo, the block shifts the right word after the next LRCK rising edge.
- WRITE_LO: wren=1, data = sample[7:0], addr = current. The address increments after every write.
- WRITE_HI: wren=1, data = sample[15:8]. Then -> SHIFT, awaiting the next channel's LRCK edge.
- Wrap: the write to address 2^BUFFER_ADDR_BITS−1 completes a half.
  - If `buffer_full_o`=0: the next cycle sets `buffer_full_o`=1, toggles `buffer_sel_o`, and sets the address to 0.
  - If `buffer_full_o`=1: set `overrun_o` and -> HOLD. In HOLD, samples are shifted but not written, and the address and sel stay frozen.
  - On ack in HOLD: the half is toggled and the address set to 0. Writing resumes at the next left frame, so stereo pairs stay aligned.
- `buffer_full_ack_i`=1 for one or more cycles clears `buffer_full_o` on the next cycle. An ack while `buffer_full_o`=0 is ignored.
- Simultaneous wrap and ack in the same cycle: the ack is processed first, so there is no overrun.
- `capture_enable_i` falling in any state -> IDLE on the next cycle. A partial sample is discarded. The address resets to 0. `buffer_sel_o` and `buffer_full_o` are retained. `overrun_o` clears.
- Sample pairs never straddle halves, because the half size is a multiple of 4.

## Timing
- BCLK edge detect latency: 3 clk from the pin to the internal pulse.
- The 16th-bit BCLK pulse is followed by WRITE_LO on the next clk, then WRITE_HI on the following clk (2 wren cycles, back-to-back).
- The wrap write is followed, 1 clk later, by `buffer_full_o`↑, the sel toggle, and the address reset, all in the same cycle.
- The ack is followed, 1 clk later, by `buffer_full_o`↓.
- Throughput: at 48 kHz stereo, a 512 B half fills in 2.67 ms.

## Configuration
- `CAPTURE_PEAK_METER_EN` defined:
  - `peak_o` tracks the maximum |sample| of stored samples (|−32768| saturates to 32767).
  - The meter is cleared in the cycle in which a half completes.
- `CAPTURE_PEAK_METER_EN` undefined: `peak_o` is tied to 0 and no meter logic is generated.

## Structure
- Shared package `capture_pkg`: the state enum, the `SAMPLE_BITS` constant, and the byte-order constant (little-endian, matching WAV).
- Sub-module `i2s_rx_shifter`: the synchronizers, BCLK/LRCK edge detection, and the 16-bit shift register with a bit counter. It outputs `sample_valid`, `sample`, and `sample_is_right`. The top level holds the FSM, addressing, and handshake.

## Test plan
- Stereo: L=0x1234, R=0xABCD -> writes 0x34, 0x12, 0xCD, 0xAB at addresses 0–3, half 0.
- Mono: L=0x00FF, R=0x7777 -> only 0xFF and 0x00 are written; the address advances by 2 per frame.
- 128 stereo frames with BUFFER_ADDR_BITS=9 -> `buffer_full_o`↑ and `buffer_sel_o`=1 one clk after the write to address 511; ack -> full↓.
- No ack over 256 frames -> `overrun_o`=1, no wren in HOLD. A later ack resumes writes at address 0 of the other half, starting on a left word.
- Enable dropped mid-word, then re-asserted -> no partial byte is written; capture restarts at address 0 on the next LRCK fall.
- With `CAPTURE_PEAK_METER_EN`: samples 0x0100, 0xF000 → `peak_o`=0x1000; cleared at half completion.
